// File: rtl/battle_pkg.sv
// Shared battle types, sprite box sizes and the box-overlap test.
// The colour mapper uses the same size constants.
package battle_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] hp_t;
    typedef logic [7:0] cnt_t;

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } tracker_state_e;

    localparam int TANK_SZ           = 16;
    localparam int BULLET_SZ         = 4;
    localparam int MINE_SZ           = 8;
    localparam int HITS_TO_KILL_DEF  = 3;
    localparam int INVULN_FRAMES_DEF = 30;

    // Inclusive-exclusive box test; one extra bit so edges near 1023 never wrap.
    function automatic logic box_overlap(
        input coord_t ax,
        input coord_t ay,
        input int     asz,
        input coord_t bx,
        input coord_t by,
        input int     bsz
    );
        logic [10:0] axw;
        logic [10:0] ayw;
        logic [10:0] bxw;
        logic [10:0] byw;
        logic [10:0] asw;
        logic [10:0] bsw;
        axw = {1'b0, ax};
        ayw = {1'b0, ay};
        bxw = {1'b0, bx};
        byw = {1'b0, by};
        asw = 11'(asz);
        bsw = 11'(bsz);
        return (axw < bxw + bsw) && (bxw < axw + asw) &&
               (ayw < byw + bsw) && (byw < ayw + asw);
    endfunction

endpackage

// File: rtl/tank_hit_tracker.sv
// Per-tank hit point, invulnerability and destroyed tracker.
// Mine hits always kill; bullet hits are ignored while invulnerable.
module tank_hit_tracker
    import battle_pkg::*;
#(
    parameter int HITS_TO_KILL  = HITS_TO_KILL_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic       fsm_clock,
    input  logic       reset,
    input  logic       bullet_hit,
    input  logic       mine_hit,
    input  logic       rearm,
    output logic [3:0] hp,
    output logic       invuln,
    output logic       gaya,
    output logic       accept
);

    localparam hp_t  HP_FULL  = hp_t'(HITS_TO_KILL);
    localparam cnt_t CNT_LOAD = cnt_t'(INVULN_FRAMES - 1);

    tracker_state_e state;
    tracker_state_e state_next;
    hp_t            hp_q;
    hp_t            hp_next;
    cnt_t           cnt;
    cnt_t           cnt_next;

    always_ff @(posedge fsm_clock) begin
        if (reset) begin
            state <= ALIVE;
            hp_q  <= HP_FULL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            hp_q  <= hp_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        hp_next    = hp_q;
        cnt_next   = cnt;
        if (rearm) begin
            state_next = ALIVE;
            hp_next    = HP_FULL;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ALIVE: begin
                    if (mine_hit || (bullet_hit && hp_q == hp_t'(1))) begin
                        state_next = DEAD;
                        hp_next    = '0;
                    end else if (bullet_hit) begin
                        state_next = INVULN;
                        hp_next    = hp_q - hp_t'(1);
                        cnt_next   = CNT_LOAD;
                    end
                end
                INVULN: begin
                    if (mine_hit) begin
                        state_next = DEAD;
                        hp_next    = '0;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = ALIVE;
                    end else begin
                        cnt_next = cnt - cnt_t'(1);
                    end
                end
                DEAD: begin
                    state_next = DEAD;
                end
                default: begin
                    state_next = ALIVE;
                end
            endcase
        end
    end

    assign hp     = hp_q;
    assign invuln = (state == INVULN);
    assign gaya   = (state == DEAD);
    assign accept = (state != DEAD);

endmodule

// File: rtl/tank_hit_detector.sv
// Frame-rate hit detection: registered box tests, then per-tank trackers.
// Also pulses bullet-consume strobes for bullets that landed.
module tank_hit_detector
    import battle_pkg::*;
#(
    parameter int HITS_TO_KILL  = HITS_TO_KILL_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic       fsm_clock,
    input  logic       reset,
    input  logic       game_on,
    input  logic [9:0] tank1_x,
    input  logic [9:0] tank1_y,
    input  logic [9:0] tank2_x,
    input  logic [9:0] tank2_y,
    input  logic [9:0] bullet1_x,
    input  logic [9:0] bullet1_y,
    input  logic       bullet1_active,
    input  logic [9:0] bullet2_x,
    input  logic [9:0] bullet2_y,
    input  logic       bullet2_active,
    input  logic [9:0] mine_x,
    input  logic [9:0] mine_y,
    input  logic       mine_active,
    output logic       tank1gaya,
    output logic       tank2gaya,
    output logic [3:0] tank1_hp,
    output logic [3:0] tank2_hp,
    output logic       tank1_invuln,
    output logic       tank2_invuln,
    output logic       bullet1_consume,
    output logic       bullet2_consume
);

    logic game_on_q;
    logic rearm;
    logic b2t1;
    logic b1t2;
    logic m_t1;
    logic m_t2;
    logic accept1;
    logic accept2;

    assign rearm = game_on & ~game_on_q;

    always_ff @(posedge fsm_clock) begin
        if (reset) begin
            game_on_q       <= 1'b0;
            b2t1            <= 1'b0;
            b1t2            <= 1'b0;
            m_t1            <= 1'b0;
            m_t2            <= 1'b0;
            bullet1_consume <= 1'b0;
            bullet2_consume <= 1'b0;
        end else begin
            game_on_q <= game_on;
            if (rearm) begin
                b2t1            <= 1'b0;
                b1t2            <= 1'b0;
                m_t1            <= 1'b0;
                m_t2            <= 1'b0;
                bullet1_consume <= 1'b0;
                bullet2_consume <= 1'b0;
            end else begin
                b2t1 <= game_on & bullet2_active &
                        box_overlap(tank1_x, tank1_y, TANK_SZ,
                                    bullet2_x, bullet2_y, BULLET_SZ);
                b1t2 <= game_on & bullet1_active &
                        box_overlap(tank2_x, tank2_y, TANK_SZ,
                                    bullet1_x, bullet1_y, BULLET_SZ);
                m_t1 <= game_on & mine_active &
                        box_overlap(tank1_x, tank1_y, TANK_SZ,
                                    mine_x, mine_y, MINE_SZ);
                m_t2 <= game_on & mine_active &
                        box_overlap(tank2_x, tank2_y, TANK_SZ,
                                    mine_x, mine_y, MINE_SZ);
                // Strobe lines up with the tracker acting on the same flag.
                bullet1_consume <= b1t2 & accept2;
                bullet2_consume <= b2t1 & accept1;
            end
        end
    end

    tank_hit_tracker #(
        .HITS_TO_KILL  (HITS_TO_KILL),
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_tracker1 (
        .fsm_clock  (fsm_clock),
        .reset      (reset),
        .bullet_hit (b2t1),
        .mine_hit   (m_t1),
        .rearm      (rearm),
        .hp         (tank1_hp),
        .invuln     (tank1_invuln),
        .gaya       (tank1gaya),
        .accept     (accept1)
    );

    tank_hit_tracker #(
        .HITS_TO_KILL  (HITS_TO_KILL),
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_tracker2 (
        .fsm_clock  (fsm_clock),
        .reset      (reset),
        .bullet_hit (b1t2),
        .mine_hit   (m_t2),
        .rearm      (rearm),
        .hp         (tank2_hp),
        .invuln     (tank2_invuln),
        .gaya       (tank2gaya),
        .accept     (accept2)
    );

endmodule
